// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmitter: register map, STATUS layout, FSM encodings.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_BAUD_DIV = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } tx_state_t;

  function automatic logic [3:0] sat_count(input int unsigned cnt);
    return (cnt > 15) ? 4'hF : 4'(cnt);
  endfunction

  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data. A push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped UART transmitter: register decode, TX FIFO, bit timer and framing FSM.
// Define UART_TX_PARITY_EN to insert an even parity bit after data bit 7 (8E1).
//
//  state  | meaning
//  IDLE   | line high, waiting for a FIFO entry
//  START  | start bit (low)
//  DATA   | 8 data bits, LSB first
//  PARITY | even parity bit (UART_TX_PARITY_EN only)
//  STOP   | stop bit (high); may chain directly into the next START
module uart_tx_peripheral
  import uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  tx_state_t   r_state;
  logic [15:0] r_timer;
  logic [15:0] r_div_frame;
  logic [15:0] r_baud_div;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic        r_tx;
  logic        r_overflow;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  logic [1:0]    w_sel;
  logic          w_wr_txdata;
  logic          w_wr_status;
  logic          w_wr_baud;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic [7:0]    w_fifo_dout;
  logic          w_timer_done;
  logic          w_pop;
  logic          w_unused;

  assign w_sel        = addr_i[3:2];
  assign w_wr_txdata  = wr_en_i && (w_sel == REG_TXDATA);
  assign w_wr_status  = wr_en_i && (w_sel == REG_STATUS);
  assign w_wr_baud    = wr_en_i && (w_sel == REG_BAUD_DIV);
  assign w_timer_done = (r_timer == 16'd0);
  // A new frame is fetched from IDLE, or at the last clock of STOP for gap-free chaining.
  assign w_pop        = !w_fifo_empty &&
                        ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_timer_done));
  assign w_unused     = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_wr_txdata),
    .i_pop   (w_pop),
    .i_data  (data_i[7:0]),
    .o_data  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_div <= DEFAULT_DIV;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_baud) r_baud_div <= clamp_div(data_i[15:0]);
      if (w_wr_txdata && w_fifo_full && !w_pop)
        r_overflow <= 1'b1;
      else if (w_wr_status && data_i[STAT_OVF])
        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= 16'd0;
      r_div_frame <= DEFAULT_DIV;
      r_shift     <= 8'd0;
      r_bit_cnt   <= 3'd0;
      r_tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      if (!w_timer_done) r_timer <= r_timer - 16'd1;
      case (r_state)
        ST_IDLE: r_tx <= 1'b1;
        ST_START: begin
          if (w_timer_done) begin
            r_tx      <= r_shift[0];
            r_timer   <= r_div_frame - 16'd1;
            r_bit_cnt <= 3'd0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_timer_done) begin
            r_timer <= r_div_frame - 16'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= ST_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
`endif
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_timer_done) begin
            r_tx    <= 1'b1;
            r_timer <= r_div_frame - 16'd1;
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_timer_done) begin
            r_tx    <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
      // Frame start overrides the IDLE/STOP defaults; the divisor is latched here for the whole frame.
      if (w_pop) begin
        r_shift     <= w_fifo_dout;
        r_div_frame <= r_baud_div;
        r_timer     <= r_baud_div - 16'd1;
        r_tx        <= 1'b0;
        r_state     <= ST_START;
`ifdef UART_TX_PARITY_EN
        r_parity    <= ^w_fifo_dout;
`endif
      end
    end
  end

  assign tx_o   = r_tx;
  assign busy_o = (r_state != ST_IDLE) || !w_fifo_empty;

  always_comb begin
    data_o = 32'd0;
    if (rd_en_i) begin
      case (w_sel)
        REG_STATUS: begin
          data_o[STAT_BUSY]           = busy_o;
          data_o[STAT_FULL]           = w_fifo_full;
          data_o[STAT_EMPTY]          = w_fifo_empty;
          data_o[STAT_OVF]            = r_overflow;
          data_o[STAT_CNT_LSB +: 4]   = sat_count(32'(w_fifo_count));
        end
        REG_BAUD_DIV: data_o[15:0] = r_baud_div;
        default:      data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Self-checking bench for uart_tx_peripheral: directed scenarios plus random traffic,
// compared every clock against a queue/timeline model of the serial line and STATUS.
module tb_uart_tx_peripheral;

  localparam int DEPTH   = 8;
  localparam int DEF_DIV = 868;
`ifdef UART_TX_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam logic [31:0] A_TX  = 32'h8000_0010;
  localparam logic [31:0] A_ST  = 32'h8000_0014;
  localparam logic [31:0] A_DIV = 32'h8000_0018;
  localparam logic [31:0] A_RSV = 32'h8000_001C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  always #5 clk = ~clk;

  uart_tx_peripheral #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd868)) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_en_i (rd_en),
    .wr_en_i (wr_en),
    .addr_i  (addr),
    .data_i  (wdata),
    .data_o  (rdata),
    .tx_o    (tx),
    .busy_o  (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct { logic [7:0] d; int p; } item_t;
  item_t      m_q[$];
  logic [7:0] m_cur = 8'd0;
  int         m_s = 0, m_end = 0, m_fdiv = 1, m_div = DEF_DIV;
  bit         m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line level after edge t: frame occupies edges [m_s, m_end), each bit m_fdiv clocks.
  function automatic logic exp_tx(input int t);
    int k;
    if (t >= m_end) return 1'b1;
    k = (t - m_s) / m_fdiv;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    if (BITS == 11 && k == 9) return ^m_cur;
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int t);
    return (t < m_end) || (m_q.size() > 0);
  endfunction

  function automatic logic [31:0] exp_status();
    int n;
    logic [31:0] s;
    n = m_q.size();
    s = 32'd0;
    s[0] = exp_busy(cyc);
    s[1] = (n == DEPTH);
    s[2] = (n == 0);
    s[3] = m_ovf;
    s[7:4] = (n > 15) ? 4'hF : 4'(n);
    return s;
  endfunction

  function automatic void model_edge(input int t, input bit r, input bit w,
                                     input logic [31:0] a, input logic [31:0] d);
    item_t it;
    if (r) begin
      m_q.delete();
      m_end = t;
      m_div = DEF_DIV;
      m_ovf = 1'b0;
      return;
    end
    // The transmitter picks up an entry on the first free edge after it was captured.
    if (t >= m_end && m_q.size() > 0 && m_q[0].p < t) begin
      m_cur  = m_q[0].d;
      m_s    = t;
      m_fdiv = m_div;
      m_end  = t + BITS * m_div;
      void'(m_q.pop_front());
    end
    if (w) begin
      case (a[3:2])
        2'd0: begin
          if (m_q.size() < DEPTH) begin
            it.d = d[7:0];
            it.p = t;
            m_q.push_back(it);
          end else m_ovf = 1'b1;
        end
        2'd1: if (d[3]) m_ovf = 1'b0;
        2'd2: m_div = (d[15:0] < 2) ? 2 : int'(d[15:0]);
        default: ;
      endcase
    end
  endfunction

  task automatic step();
    bit r, w;
    logic [31:0] a, d;
    r = rst; w = wr_en; a = addr; d = wdata;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(cyc, r, w, a, d);
    chk("tx_o", {31'd0, tx}, {31'd0, exp_tx(cyc)});
    chk("busy_o", {31'd0, busy}, {31'd0, exp_busy(cyc)});
    chk("data_o_idle", rdata, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; rd_en = 1'b1;
    #1;
    chk(tag, rdata, exp);
    rd_en = 1'b0;
    #1;
  endtask

  task automatic drain();
    int b = 0;
    while ((cyc < m_end || m_q.size() > 0) && b < 20000) begin
      step();
      b++;
    end
    chk("drain_bound", {31'd0, (b >= 20000)}, 32'd0);
    repeat (3) step();
  endtask

  function automatic logic [31:0] rnd_addr(input logic [1:0] sel);
    logic [31:0] a;
    a = $urandom;
    a[3:2] = sel;
    return a;
  endfunction

  initial begin
    int target;
    int r;
    repeat (2) step();
    rst = 1'b0;
    step();
    rd_chk("reset_status", A_ST, exp_status());
    rd_chk("reset_baud", A_DIV, 32'd868);

    // Basic frame at divisor 4.
    wr(A_DIV, 32'd4);
    wr(A_TX, 32'hA5);
    drain();

    // Three back-to-back pushes: count reads 2, frames chain with no gap.
    wr(A_TX, 32'h01); wr(A_TX, 32'h02); wr(A_TX, 32'h03);
    rd_chk("b2b_status", A_ST, exp_status());
    drain();

    // Overflow: ten pushes while the first frame is in flight.
    for (int i = 0; i < 10; i++) wr(A_TX, 32'h10 + i);
    rd_chk("ovf_status", A_ST, exp_status());
    rd_chk("ovf_status_const", A_ST, {24'd0, 4'd8, 4'b1011});
    wr(A_ST, 32'h8);
    rd_chk("ovf_cleared", A_ST, exp_status());
    drain();

    // Divisor clamp and mid-frame divisor change.
    wr(A_DIV, 32'd0);
    rd_chk("baud_clamp", A_DIV, 32'd2);
    wr(A_TX, 32'h3C);
    repeat (5) step();
    wr(A_DIV, 32'd6);
    wr(A_TX, 32'hC3);
    drain();
    rd_chk("baud_six", A_DIV, 32'd6);

    // Reset during data bit 3 with entries still queued.
    wr(A_DIV, 32'd4);
    wr(A_TX, 32'h5A); wr(A_TX, 32'h11); wr(A_TX, 32'h22);
    target = m_s + 17;
    while (cyc < target) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_chk("rst_mid_status", A_ST, 32'h0000_0004);
    rd_chk("rst_mid_baud", A_DIV, 32'd868);
    step();

    // Parity case byte.
    wr(A_DIV, 32'd3);
    wr(A_TX, 32'h07);
    drain();

    // Random traffic with random upper address bits.
    for (int round = 0; round < 4; round++) begin
      wr(rnd_addr(2'd2), 32'($urandom_range(0, 5)));
      for (int i = 0; i < 400; i++) begin
        r = $urandom_range(0, 99);
        if (r < 25) wr(rnd_addr(2'd0), $urandom);
        else if (r < 28) wr(rnd_addr(2'd1), $urandom);
        else if (r < 33) rd_chk("rnd_status", rnd_addr(2'd1), exp_status());
        else if (r < 35) wr(rnd_addr(2'd2), 32'($urandom_range(0, 5)));
        else if (r < 36) wr(rnd_addr(2'd3), $urandom);
        else if (r < 37) rd_chk("rnd_reserved", rnd_addr(2'd3), 32'd0);
        else if (r < 38) rd_chk("rnd_txdata_rd", rnd_addr(2'd0), 32'd0);
        else if (r < 39) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          wr(A_DIV, 32'($urandom_range(2, 5)));
        end else step();
      end
      rd_chk("rnd_baud", A_DIV, 32'(m_div));
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
